// File: rtl/alu_cmd_sequencer_if.sv
// Command handshake and ALU operand/result bus between a command source,
// the sequencer, and the 4-bit combinational ALU.
interface alu_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_code;
  logic [3:0] cmd_data;
  logic [2:0] alu_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_result;
  logic       alu_zero;
  logic       alu_carry;

  // Master is the environment: it issues commands and plays the ALU.
  modport master (
    output cmd_valid, cmd_code, cmd_data, alu_result, alu_zero, alu_carry,
    input  cmd_ready, alu_op, alu_a, alu_b
  );

  modport slave (
    input  cmd_valid, cmd_code, cmd_data, alu_result, alu_zero, alu_carry,
    output cmd_ready, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Accumulator-based command sequencer for a 4-bit combinational ALU.
// MUL is executed as repeated ALU additions, one per cycle.
module alu_cmd_sequencer #(
  parameter logic [3:0] ACC_INIT = 4'h0
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_cmd_sequencer_if.slave   bus,
  output logic [3:0]           acc,
  output logic                 zero_q,
  output logic                 carry_q,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;

  logic [1:0] r_state;
  logic [3:0] r_acc;
  logic       r_zero;
  logic       r_carry;
  logic [3:0] r_b;
  logic [2:0] r_op;
  logic [3:0] r_m;
  logic [3:0] r_cnt;
  logic       r_sticky;

  logic       w_accept;
  logic       w_is_nop;
  logic       w_mul_step;

  assign bus.cmd_ready = (r_state == S_IDLE) && !reset;
  assign w_accept      = bus.cmd_valid && bus.cmd_ready;
  assign w_is_nop      = (r_op[2:1] == 2'b10);
  assign w_mul_step    = (r_state == S_MUL) && (r_cnt != 4'd0);

  assign acc     = r_acc;
  assign zero_q  = r_zero;
  assign carry_q = r_carry;
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);

  // NOTE: every output gets its default before the branches, so no latch is inferred.
  always_comb begin
    bus.alu_op = OP_AND;
    bus.alu_a  = r_acc;
    bus.alu_b  = 4'h0;
    if (r_state == S_EXEC) begin
      bus.alu_op = r_op;
      bus.alu_b  = r_b;
    end else if (w_mul_step) begin
      bus.alu_op = OP_ADD;
      bus.alu_b  = r_m;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_acc    <= ACC_INIT;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_b      <= 4'h0;
      r_op     <= OP_AND;
      r_m      <= 4'h0;
      r_cnt    <= 4'd0;
      r_sticky <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (bus.cmd_code == OP_MUL) begin
              r_m      <= r_acc;
              r_cnt    <= bus.cmd_data;
              r_acc    <= 4'h0;
              r_sticky <= 1'b0;
              r_state  <= S_MUL;
            end else begin
              r_b     <= bus.cmd_data;
              r_op    <= bus.cmd_code;
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (!w_is_nop) begin
            r_acc   <= bus.alu_result;
            r_zero  <= bus.alu_zero;
            r_carry <= bus.alu_carry;
          end
          r_state <= S_DONE;
        end
        S_MUL: begin
          if (w_mul_step) begin
            r_acc    <= bus.alu_result;
            r_sticky <= r_sticky | bus.alu_carry;
            r_cnt    <= r_cnt - 4'd1;
          end else begin
            // Sticky carry flags any overflow across the whole product.
            r_zero  <= (r_acc == 4'h0);
            r_carry <= r_sticky;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench: plays the ALU, issues commands, and scoreboards
// accumulator, flags and done latency against a reference model.
module tb_alu_cmd_sequencer;
  localparam logic [3:0] ACC_INIT = 4'h0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] acc;
  logic       zero_q;
  logic       carry_q;
  logic       busy;
  logic       done;

  alu_cmd_sequencer_if bus();

  alu_cmd_sequencer #(.ACC_INIT(ACC_INIT)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .acc     (acc),
    .zero_q  (zero_q),
    .carry_q (carry_q),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational ALU: SUB carry means "no borrow".
  logic [4:0] alu_sum;
  always_comb begin
    alu_sum = 5'd0;
    case (bus.alu_op)
      3'b000:  alu_sum = {1'b0, bus.alu_a & bus.alu_b};
      3'b001:  alu_sum = {1'b0, bus.alu_a | bus.alu_b};
      3'b010:  alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      3'b110:  alu_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 5'd1;
      3'b111:  alu_sum = {1'b0, bus.alu_b};
      default: alu_sum = 5'd0;
    endcase
  end
  assign bus.alu_result = alu_sum[3:0];
  assign bus.alu_carry  = alu_sum[4];
  assign bus.alu_zero   = (alu_sum[3:0] == 4'h0);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [3:0] acc;
    logic       z;
    logic       c;
    int         lat;
    int         t_acc;
  } exp_t;

  exp_t sb[$];

  logic [3:0] m_acc = ACC_INIT;
  logic       m_z   = 1'b0;
  logic       m_c   = 1'b0;
  int         last_acc_cyc = 0;
  bit         b2b = 1'b0;

  // Reference model: updates the architectural state and returns expectations.
  task automatic model(input logic [2:0] code, input logic [3:0] data, output exp_t e);
    int p;
    e.lat = 2;
    case (code)
      3'b000: begin m_acc = m_acc & data; m_c = 1'b0; m_z = (m_acc == 0); end
      3'b001: begin m_acc = m_acc | data; m_c = 1'b0; m_z = (m_acc == 0); end
      3'b010: begin
        p = int'(m_acc) + int'(data);
        m_acc = p[3:0]; m_c = (p > 15); m_z = (m_acc == 0);
      end
      3'b110: begin
        m_c = (m_acc >= data); m_acc = m_acc - data; m_z = (m_acc == 0);
      end
      3'b111: begin m_acc = data; m_c = 1'b0; m_z = (m_acc == 0); end
      3'b011: begin
        p = int'(m_acc) * int'(data);
        m_acc = p[3:0]; m_c = (p > 15); m_z = (m_acc == 0);
        e.lat = 2 + int'(data);
      end
      default: ;
    endcase
    e.acc = m_acc;
    e.z   = m_z;
    e.c   = m_c;
  endtask

  // Monitor, sampled 1 time unit after the rising edge.
  always @(posedge clk) begin
    exp_t e;
    logic exp_busy;
    #1;
    if (!reset) begin
      check("ready_while_busy", bus.cmd_ready & busy, 1'b0);
      exp_busy = 1'b0;
      if (sb.size() != 0) exp_busy = (cyc > sb[0].t_acc);
      check("busy", busy, exp_busy);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", done, 1'b0);
        end else begin
          e = sb.pop_front();
          check("done_latency", cyc - e.t_acc, e.lat);
          check("acc", acc, e.acc);
          check("zero_q", zero_q, e.z);
          check("carry_q", carry_q, e.c);
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [2:0] code, input logic [3:0] data, input bit hold);
    exp_t e;
    int budget;
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = code;
    bus.cmd_data  = data;
    budget = 0;
    while (!bus.cmd_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.cmd_ready) begin
      check("accept_timeout", bus.cmd_ready, 1'b1);
      bus.cmd_valid = 1'b0;
      return;
    end
    model(code, data, e);
    e.t_acc = cyc;
    sb.push_back(e);
    if (b2b) check("accept_spacing", cyc - last_acc_cyc, 3);
    last_acc_cyc = cyc;
    @(negedge clk);
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() != 0) begin
      check("idle_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic reset_checks();
    check("rst_ready", bus.cmd_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_acc", acc, ACC_INIT);
    check("rst_zero", zero_q, 1'b0);
    check("rst_carry", carry_q, 1'b0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_code  = 3'b000;
    bus.cmd_data  = 4'h0;

    repeat (2) @(negedge clk);
    reset_checks();
    reset = 1'b0;
    #1;
    check("ready_after_reset", bus.cmd_ready, 1'b1);
    @(negedge clk);

    send(3'b111, 4'hA, 1'b0); wait_idle();

    send(3'b111, 4'h9, 1'b0); send(3'b010, 4'h8, 1'b0); wait_idle();
    send(3'b000, 4'h0, 1'b0); wait_idle();

    send(3'b111, 4'h5, 1'b0); send(3'b110, 4'h5, 1'b0); wait_idle();
    send(3'b111, 4'h3, 1'b0); send(3'b110, 4'h5, 1'b0); wait_idle();

    send(3'b111, 4'h3, 1'b0); send(3'b011, 4'h5, 1'b0); wait_idle();
    send(3'b111, 4'h6, 1'b0); send(3'b011, 4'h3, 1'b0); wait_idle();
    send(3'b111, 4'h7, 1'b0); send(3'b011, 4'h0, 1'b0); wait_idle();

    // Back-to-back with cmd_valid held high.
    b2b = 1'b0;
    send(3'b111, 4'h4, 1'b1);
    b2b = 1'b1;
    send(3'b010, 4'h1, 1'b1);
    send(3'b100, 4'h7, 1'b1);
    send(3'b001, 4'h8, 1'b0);
    b2b = 1'b0;
    wait_idle();
    check("b2b_final_acc", acc, 4'hD);

    // NOP (101) must preserve carry and zero set by the preceding ADD.
    send(3'b111, 4'hF, 1'b0); send(3'b010, 4'h1, 1'b0); send(3'b101, 4'h3, 1'b0);
    wait_idle();

    // Reset in the middle of MUL 9.
    send(3'b111, 4'h2, 1'b0);
    send(3'b011, 4'h9, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset_checks();
    m_acc = ACC_INIT; m_z = 1'b0; m_c = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_after_abort", bus.cmd_ready, 1'b1);
    @(negedge clk);
    send(3'b111, 4'h1, 1'b0); wait_idle();

    // Random mix, including the NOP codes and MUL counts up to 15.
    for (int i = 0; i < 24; i++) begin
      send(3'($urandom_range(7, 0)), 4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)));
    end
    bus.cmd_valid = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
